// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator core: key codes, FSM states,
// operation codes and flag bit positions.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CE  = 4'd14;
    localparam logic [3:0] KEY_C   = 4'd15;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTER_B = 3'd2,
        CALC    = 3'd3,
        RESULT  = 3'd4,
        ERROR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    // Bit positions inside the {C,V,N,Z} flags word.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    function automatic op_t key_to_op(input logic [3:0] code);
        case (code)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential signed multiplier: magnitudes are shift-added over WIDTH cycles
// and the sign is applied to the full 2*WIDTH product at the end.
module calc_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Handshake: start is a one-cycle pulse that samples a and b; done pulses
    // for one cycle WIDTH cycles later and product stays valid until the next
    // start. abort (or reset) cancels any run in progress and suppresses done.
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [IW-1:0]      iter;
    logic               running;
    logic               neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            iter    <= '0;
            running <= 1'b0;
            neg     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{WIDTH{1'b0}}, mag(a)};
                mplier  <= mag(b);
                acc     <= '0;
                iter    <= '0;
                neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                iter   <= iter + IW'(1);
                if (iter == IW'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = neg ? (~acc + 1'b1) : acc;

endmodule

// File: rtl/calc_core_p.sv
// Keypad calculator core: builds decimal operands from key events, runs
// add/sub/multiply with chaining, and drives the display value and flags.
module calc_core_p
    import calc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int MUL_EN     = 1,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] disp_val,
    output logic [1:0]       disp_src,
    output logic [3:0]       flags,
    output logic             err,
    output logic             busy,
    output logic [CW-1:0]    digit_cnt,
    output state_t           dbg_state,
    output op_t              dbg_op
);

    // Key handshake: a key is consumed on a rising edge where key_valid and
    // key_ready are both high; nothing is queued. C bypasses key_ready.
    localparam int EW = WIDTH + 5;
    localparam logic [EW-1:0] MAX_POS = {{(EW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};

    state_t             state, state_nxt;
    op_t                op, op_nxt, pend, pend_nxt;
    logic [WIDTH-1:0]   a, a_nxt, b, b_nxt, r, r_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic [3:0]         flags_nxt;
    logic               chain, chain_nxt;

    logic               key_take, key_clear, is_digit, is_op, digit_fits;
    logic [WIDTH-1:0]   acc_sel;
    logic [EW-1:0]      acc_new;
    logic [WIDTH:0]     sum_w, dif_w;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, calc_done;
    logic               mul_start, mul_abort, mul_done;
    logic [2*WIDTH-1:0] mul_p;

    function automatic logic [3:0] mk_flags(input logic c, input logic v,
                                            input logic [WIDTH-1:0] val);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = val[WIDTH-1];
        f[FLAG_Z] = (val == '0);
        return f;
    endfunction

    assign key_clear  = key_valid && (key_code == KEY_C);
    assign key_take   = key_valid && key_ready;
    assign is_digit   = (key_code <= 4'd9);
    assign is_op      = (key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                        ((MUL_EN != 0) && (key_code == KEY_MUL));
    assign acc_sel    = (state == ENTER_B) ? b : a;
    assign acc_new    = EW'(acc_sel) * EW'(10) + EW'(key_code);
    assign digit_fits = (digit_cnt != CW'(MAX_DIGITS)) && (acc_new <= MAX_POS);

    assign sum_w = {1'b0, a} + {1'b0, b};
    assign dif_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = dif_w[WIDTH-1:0];
                res_c = dif_w[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                // In range only when the upper WIDTH+1 bits are a pure sign extension.
                res   = mul_p[WIDTH-1:0];
                res_v = !((&mul_p[2*WIDTH-1:WIDTH-1]) || !(|mul_p[2*WIDTH-1:WIDTH-1]));
            end
            default: ;
        endcase
    end

    assign calc_done = (op == OP_MUL) ? mul_done : 1'b1;

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        pend_nxt  = pend;
        a_nxt     = a;
        b_nxt     = b;
        r_nxt     = r;
        cnt_nxt   = digit_cnt;
        flags_nxt = flags;
        chain_nxt = chain;
        if (key_clear) begin
            state_nxt = ENTER_A;
            op_nxt    = OP_ADD;
            pend_nxt  = OP_ADD;
            a_nxt     = '0;
            b_nxt     = '0;
            r_nxt     = '0;
            cnt_nxt   = '0;
            flags_nxt = '0;
            chain_nxt = 1'b0;
        end else begin
            case (state)
                ENTER_A: if (key_take) begin
                    if (is_digit) begin
                        if (digit_fits) begin
                            a_nxt   = acc_new[WIDTH-1:0];
                            cnt_nxt = digit_cnt + CW'(1);
                        end
                    end else if (is_op) begin
                        op_nxt    = key_to_op(key_code);
                        cnt_nxt   = '0;
                        state_nxt = OP_WAIT;
                    end else if (key_code == KEY_EQ) begin
                        r_nxt     = a;
                        flags_nxt = mk_flags(1'b0, 1'b0, a);
                        state_nxt = RESULT;
                    end else if (key_code == KEY_CE) begin
                        a_nxt   = '0;
                        cnt_nxt = '0;
                    end
                end
                OP_WAIT: if (key_take) begin
                    if (is_digit) begin
                        b_nxt     = WIDTH'(key_code);
                        cnt_nxt   = CW'(1);
                        state_nxt = ENTER_B;
                    end else if (is_op) begin
                        op_nxt = key_to_op(key_code);
                    end
                end
                ENTER_B: if (key_take) begin
                    if (is_digit) begin
                        if (digit_fits) begin
                            b_nxt   = acc_new[WIDTH-1:0];
                            cnt_nxt = digit_cnt + CW'(1);
                        end
                    end else if (is_op) begin
                        pend_nxt  = key_to_op(key_code);
                        chain_nxt = 1'b1;
                        state_nxt = CALC;
                    end else if (key_code == KEY_EQ) begin
                        chain_nxt = 1'b0;
                        state_nxt = CALC;
                    end else if (key_code == KEY_CE) begin
                        b_nxt   = '0;
                        cnt_nxt = '0;
                    end
                end
                CALC: if (calc_done) begin
                    r_nxt     = res;
                    flags_nxt = mk_flags(res_c, res_v, res);
                    if (res_v) begin
                        state_nxt = ERROR;
                    end else if (chain) begin
                        a_nxt     = res;
                        op_nxt    = pend;
                        cnt_nxt   = '0;
                        state_nxt = OP_WAIT;
                    end else begin
                        state_nxt = RESULT;
                    end
                end
                RESULT: if (key_take) begin
                    if (is_digit) begin
                        a_nxt     = WIDTH'(key_code);
                        cnt_nxt   = CW'(1);
                        flags_nxt = '0;
                        state_nxt = ENTER_A;
                    end else if (is_op) begin
                        a_nxt     = r;
                        op_nxt    = key_to_op(key_code);
                        cnt_nxt   = '0;
                        state_nxt = OP_WAIT;
                    end else if (key_code == KEY_CE) begin
                        a_nxt     = '0;
                        cnt_nxt   = '0;
                        state_nxt = ENTER_A;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands are final on the edge that leaves ENTER_B, so the multiplier
    // samples them on that same edge.
    assign mul_start = (state == ENTER_B) && (state_nxt == CALC) && (op == OP_MUL);
    assign mul_abort = key_clear;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ENTER_A;
            op        <= OP_ADD;
            pend      <= OP_ADD;
            a         <= '0;
            b         <= '0;
            r         <= '0;
            digit_cnt <= '0;
            flags     <= '0;
            chain     <= 1'b0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            pend      <= pend_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            r         <= r_nxt;
            digit_cnt <= cnt_nxt;
            flags     <= flags_nxt;
            chain     <= chain_nxt;
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (CLK),
                .rst_n   (RST),
                .start   (mul_start),
                .abort   (mul_abort),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_p)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_p    = '0;
        end
    endgenerate

    always_comb begin
        disp_val = a;
        disp_src = 2'd0;
        case (state)
            ENTER_B, CALC: begin
                disp_val = b;
                disp_src = 2'd1;
            end
            RESULT: begin
                disp_val = r;
                disp_src = 2'd2;
            end
            ERROR: begin
                disp_val = '0;
                disp_src = 2'd3;
            end
            default: ;
        endcase
    end

    assign key_ready = (state != CALC);
    assign busy      = (state == CALC);
    assign err       = (state == ERROR);
    assign dbg_state = state;
    assign dbg_op    = op;

endmodule

// File: tb/tb_calc_core_p.sv
// Directed bench for calc_core_p: key sequences with hand-computed displays,
// flags, busy lengths and state.
module tb_calc_core_p;
    import calc_pkg::*;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [7:0] disp_val;
    logic [1:0] disp_src;
    logic [3:0] flags;
    logic       err;
    logic       busy;
    logic [1:0] digit_cnt;
    state_t     dbg_state;
    op_t        dbg_op;

    int tests;
    int fails;
    int busy_cycles;

    calc_core_p #(.WIDTH(8), .MAX_DIGITS(3), .MUL_EN(1)) dut (
        .CLK       (clk),
        .RST       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .disp_val  (disp_val),
        .disp_src  (disp_src),
        .flags     (flags),
        .err       (err),
        .busy      (busy),
        .digit_cnt (digit_cnt),
        .dbg_state (dbg_state),
        .dbg_op    (dbg_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    // Counts the cycles spent busy after a key, bounded.
    task automatic settle();
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 100) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic keys(input string s);
        logic [3:0] code;
        byte        c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            case (c)
                "+":     code = KEY_ADD;
                "-":     code = KEY_SUB;
                "*":     code = KEY_MUL;
                "=":     code = KEY_EQ;
                "E":     code = KEY_CE;
                "C":     code = KEY_C;
                default: code = 4'(c - 8'd48);
            endcase
            press(code);
            settle();
        end
    endtask

    initial begin
        int n;
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        check("rst_state", 32'(dbg_state), 32'(ENTER_A));
        check("rst_disp", 32'(disp_val), 32'd0);
        check("rst_src", 32'(disp_src), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_err_busy", {30'd0, err, busy}, 32'd0);
        check("rst_ready", 32'(key_ready), 32'd1);
        check("rst_cnt", 32'(digit_cnt), 32'd0);

        // 12 + 34 = 46, add takes one busy cycle
        keys("12");
        check("a12_disp", 32'(disp_val), 32'd12);
        check("a12_cnt", 32'(digit_cnt), 32'd2);
        keys("+34");
        check("b34_src", 32'(disp_src), 32'd1);
        check("b34_disp", 32'(disp_val), 32'd34);
        keys("=");
        check("add_busy", 32'(busy_cycles), 32'd1);
        check("add_disp", 32'(disp_val), 32'd46);
        check("add_src", 32'(disp_src), 32'd2);
        check("add_flags", 32'(flags), 32'b0000);
        check("add_state", 32'(dbg_state), 32'(RESULT));

        // digit in RESULT starts a fresh A and clears flags
        keys("C5-9=");
        check("sub_disp", 32'(disp_val), 32'hFC);
        check("sub_flags", 32'(flags), 32'b1010);
        keys("7");
        check("res_digit_state", 32'(dbg_state), 32'(ENTER_A));
        check("res_digit_disp", 32'(disp_val), 32'd7);
        check("res_digit_flags", 32'(flags), 32'd0);

        // overflow 100+100 -> ERROR, only C leaves
        keys("C100+100=");
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_state", 32'(dbg_state), 32'(ERROR));
        check("ovf_flags", 32'(flags), 32'b0110);
        check("ovf_disp", 32'(disp_val), 32'd0);
        check("ovf_src", 32'(disp_src), 32'd3);
        keys("5E=");
        check("err_stuck", 32'(dbg_state), 32'(ERROR));
        keys("C");
        check("clr_state", 32'(dbg_state), 32'(ENTER_A));
        check("clr_flags", 32'(flags), 32'd0);
        check("clr_disp", {22'd0, err, disp_src, disp_val[6:0]}, 32'd0);

        // chaining: 7+8- gives A=15 with SUB latched, then 5= gives 10
        keys("7+8-");
        check("chain_state", 32'(dbg_state), 32'(OP_WAIT));
        check("chain_disp", 32'(disp_val), 32'd15);
        check("chain_op", 32'(dbg_op), 32'(OP_SUB));
        keys("5=");
        check("chain_res", 32'(disp_val), 32'd10);
        check("chain_flags", 32'(flags), 32'd0);

        // 12*10: 9 busy cycles, digit during busy dropped
        keys("C12*10");
        press(KEY_EQ);
        n = 0;
        while (busy && n < 100) begin
            if (n == 2) begin
                check("mul_ready_low", 32'(key_ready), 32'd0);
                key_valid = 1'b1;
                key_code  = 4'd5;
            end else begin
                key_valid = 1'b0;
                key_code  = 4'd0;
            end
            n++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("mul_busy", 32'(n), 32'd9);
        check("mul_disp", 32'(disp_val), 32'd120);
        check("mul_state", 32'(dbg_state), 32'(RESULT));
        check("mul_cnt", 32'(digit_cnt), 32'd2);

        // C mid-multiply aborts to ENTER_A on the next cycle
        keys("C12*10");
        press(KEY_EQ);
        repeat (3) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        press(KEY_C);
        check("abort_state", 32'(dbg_state), 32'(ENTER_A));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_disp", 32'(disp_val), 32'd0);
        keys("3+4=");
        check("after_abort", 32'(disp_val), 32'd7);

        // signed multiply through a chain: (5-9)*3 = -12
        keys("C5-9*3=");
        check("neg_mul_disp", 32'(disp_val), 32'hF4);
        check("neg_mul_flags", 32'(flags), 32'b0010);
        keys("C20*10=");
        check("mul_ovf_err", 32'(err), 32'd1);

        // '=' straight from ENTER_A
        keys("C0=");
        check("eq_a_flags", 32'(flags), 32'b0001);
        check("eq_a_src", 32'(disp_src), 32'd2);

        // digit limits
        keys("C128");
        check("lim_val_disp", 32'(disp_val), 32'd12);
        check("lim_val_cnt", 32'(digit_cnt), 32'd2);
        keys("C0005");
        check("lim_cnt_disp", 32'(disp_val), 32'd0);
        check("lim_cnt_cnt", 32'(digit_cnt), 32'd3);
        keys("C12E3");
        check("ce_disp", 32'(disp_val), 32'd3);
        check("ce_cnt", 32'(digit_cnt), 32'd1);

        // RST during ENTER_B with non-zero flags
        keys("C5-9=+4");
        check("pre_rst_state", 32'(dbg_state), 32'(ENTER_B));
        check("pre_rst_flags", 32'(flags), 32'b1010);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst2_state", 32'(dbg_state), 32'(ENTER_A));
        check("rst2_disp", {22'd0, disp_src, disp_val}, 32'd0);
        check("rst2_flags", 32'(flags), 32'd0);
        check("rst2_cnt", 32'(digit_cnt), 32'd0);
        check("rst2_ctl", {29'd0, err, busy, key_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_core_p.md
Name: calc_core_p

Overview:
- Parametrised successor to the 8-bit keypad calculator datapath and control.
- Accepts decoded keypad events from the keypad scanner, builds decimal operands and runs add, subtract and optional sequential multiply.
- Supports chained operations, clear-entry and clear-all.
- Presents the operand or result to be displayed, plus status flags, to the seven-segment output unit.
- Replaces the separate control-unit/arithmetic-unit pair with one clocked block that has explicit error and busy handling.

Parameters:
- WIDTH, 8: operand/result width, two's complement signed.
- MAX_DIGITS, 3: maximum decimal digits accepted per operand.
- MUL_EN, 1: 1 enables the '*' key and the sequential multiplier; 0 makes '*' an ignored key.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 CE, 15 C.
- key_ready  out  1  high when keys are accepted; low only in CALC.
- disp_val  out  WIDTH  signed value to display.
- disp_src  out  2  source of disp_val: 0 A, 1 B, 2 R, 3 error.
- flags  out  4  {C,V,N,Z} from the last completed operation.
- err  out  1  high in ERROR state.
- busy  out  1  high in CALC.
- digit_cnt  out  $clog2(MAX_DIGITS+1)  digits entered in the current operand.

Behaviour:
- Reset: RST low at a clock edge forces:
  - state ENTER_A
  - A, B, R, op, digit_cnt, flags, disp_val all 0
  - disp_src 0, err 0, busy 0, key_ready 1
- Reset mid-CALC aborts the multiplier.
- Key acceptance: a key is taken only when key_valid=1 and key_ready=1. Exception: C (15) is honoured in every state, including CALC, and acts like reset one cycle later. Keys while key_ready=0 are dropped, not queued.
- Digit entry: new = acc*10 + d.
  - Rejected (acc unchanged) if digit_cnt==MAX_DIGITS or new > 2^(WIDTH-1)-1.
  - Otherwise acc=new and digit_cnt++.
  - Leading zero: acc stays 0, digit_cnt still increments.
- States and transitions:
  - ENTER_A (disp A):
    - digit → accumulate into A.
    - op key → latch op, digit_cnt=0, go to OP_WAIT.
    - '=' → R=A, flags Z/N from A with C=V=0, go to RESULT.
    - CE → A=0, digit_cnt=0.
  - OP_WAIT (disp A):
    - digit → B=d, digit_cnt=1, go to ENTER_B.
    - op key → replace the latched op.
    - '=' and CE are ignored.
  - ENTER_B (disp B):
    - digit → accumulate into B.
    - op key → store it as pending_op, set chain=1, go to CALC.
    - '=' → chain=0, go to CALC.
    - CE → B=0, digit_cnt=0.
  - CALC (disp B, busy=1, key_ready=0):
    - Add/sub completes in 1 cycle.
    - Multiply completes in WIDTH+1 cycles.
    - On completion: if V=1 go to ERROR; else if chain=1 then A=R, op=pending_op, digit_cnt=0, go to OP_WAIT; else go to RESULT.
  - RESULT (disp R):
    - digit → A=d, digit_cnt=1, flags=0, go to ENTER_A.
    - op key → A=R, latch op, go to OP_WAIT.
    - CE → A=0, go to ENTER_A.
    - '=' is ignored.
  - ERROR (disp 0, disp_src 3, err=1): only C leaves this state.
- Arithmetic:
  - Add/sub is done at WIDTH+1 bits.
  - C = unsigned carry out for add, unsigned borrow for sub.
  - V = signed overflow.
  - N = R[WIDTH-1]; Z = (R==0).
  - Multiply: signed via magnitudes and a shift-add over WIDTH iterations, giving a 2*WIDTH product with the sign applied at the end. V=1 if the product is outside the signed WIDTH range; C=0.
  - On V=1, R holds the wrapped value but disp_val shows 0.
- Flags update only when CALC completes, on '=' in ENTER_A, or on the clears described above.

Decomposition:
- calc_pkg holds:
  - key code localparams (KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_EQ=13, KEY_CE=14, KEY_C=15)
  - the state encoding (ENTER_A, OP_WAIT, ENTER_B, CALC, RESULT, ERROR)
  - the op encoding (OP_ADD, OP_SUB, OP_MUL)
  - flag bit indices
- Sub-module calc_mul_seq (WIDTH): start/done handshake, abort input tied to the C key, 2*WIDTH product output. Instantiated only when MUL_EN=1.

Test Plan:
- Keys 1,2,+,3,4,= → RESULT with disp_val=46 and flags=0000; busy high for exactly 1 cycle.
- Keys 5,-,9,= → disp_val=8'hFC (-4) and flags=C1 V0 N1 Z0.
- Keys 1,0,0,+,1,0,0,= → ERROR with err=1, V=1, disp_val=0. Digits and CE are then ignored; C returns to ENTER_A with all state zero.
- Keys 7,+,8,-,5,= → after '-': A=15, state OP_WAIT, op=SUB. Final result 10.
- MUL_EN=1, keys 1,2,*,1,0,= → busy for 9 cycles, a digit pressed during busy is dropped, result 120. Then C pressed mid-multiply in a repeat run → ENTER_A on the next cycle.
- Keys 1,2,8 → A stays 12 (128 rejected). Keys 0,0,0,5 → A=0 with the 4th digit rejected. RST low for one edge during ENTER_B → all outputs return to reset values.
